// File: rtl/imem_refill_responder_if.sv
// Bus bundle between the cache refill controller (master) and the instruction
// memory responder (slave), plus the program-loader write port.
//
// Handshake: the master raises instructionRequest with a stable
// instructionAddress and holds it high until it has seen receivedInstruction.
// receivedInstruction is a one-cycle valid pulse that qualifies instruction,
// cacheData and addrError. Dropping the request before the pulse cancels the
// transaction, and no pulse follows. A request still high after its pulse is
// not serviced again; the responder waits for it to fall first.
// progWrite is a single-cycle write strobe with no back-pressure.
interface imem_refill_responder_if;
  logic        instructionRequest;
  logic [31:0] instructionAddress;
  logic        progWrite;
  logic [31:0] progAddress;
  logic [31:0] progData;
  logic        receivedInstruction;
  logic [31:0] instruction;
  logic [63:0] cacheData;
  logic        addrError;
  logic        busy;

  modport slave (
    input  instructionRequest,
    input  instructionAddress,
    input  progWrite,
    input  progAddress,
    input  progData,
    output receivedInstruction,
    output instruction,
    output cacheData,
    output addrError,
    output busy
  );

  modport master (
    output instructionRequest,
    output instructionAddress,
    output progWrite,
    output progAddress,
    output progData,
    input  receivedInstruction,
    input  instruction,
    input  cacheData,
    input  addrError,
    input  busy
  );
endinterface

// File: rtl/imem_refill_responder.sv
// Instruction memory refill responder. It services one cache-line refill at a
// time after a fixed number of wait cycles. It returns the requested word and
// the 8-byte line that contains it. Misaligned and out-of-range requests return
// a filler word (0x00000033) with addrError set. A loader port writes the
// backing array in any state. Reset does not clear the array.
module imem_refill_responder #(
  parameter int LATENCY     = 4,     // wait cycles, legal range 1..15
  parameter int DEPTH_WORDS = 1024   // power of two, >= 2
) (
  input  logic                          clk,
  input  logic                          reset,      // asynchronous, active low
  imem_refill_responder_if.slave        bus,
  output logic [1:0]                    fsm_state   // debug view of the FSM
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] FILLER   = 32'h0000_0033;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic [31:0]   addr_q;

  // FSM strobes
  logic          capture;   // IDLE accepts a request
  logic          count_dec; // WAIT still counting down
  logic          fire;      // WAIT->RESP edge: register the response

  // Backing array, deliberately left out of reset
  logic [31:0]   mem [DEPTH_WORDS];

  // Lookup on the latched request address
  logic [AW-1:0] word_idx;
  logic [AW-1:0] line_lo_idx;
  logic [AW-1:0] line_hi_idx;
  logic          req_in_range;
  logic          req_aligned;
  logic          req_bad;

  // Loader address decode
  logic [AW-1:0] prog_idx;
  logic          prog_in_range;
  logic          prog_byte_lane_unused;

  assign word_idx     = addr_q[AW+1:2];
  assign line_lo_idx  = word_idx & ~AW'(1);
  assign line_hi_idx  = word_idx |  AW'(1);
  assign req_in_range = (addr_q[31:AW+2] == '0);
  assign req_aligned  = (addr_q[1:0] == 2'b00);
  assign req_bad      = !(req_in_range && req_aligned);

  assign prog_idx              = bus.progAddress[AW+1:2];
  assign prog_in_range         = (bus.progAddress[31:AW+2] == '0);
  assign prog_byte_lane_unused = &{1'b0, bus.progAddress[1:0]};

  assign bus.busy  = (state != S_IDLE);
  assign fsm_state = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    count_dec  = 1'b0;
    fire       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.instructionRequest) begin
          capture    = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.instructionRequest) begin
          // Request withdrawn: abort with no pulse. Outputs keep their old values.
          state_next = S_IDLE;
        end else if (cnt == 4'd0) begin
          fire       = 1'b1;
          state_next = S_RESP;
        end else begin
          count_dec  = 1'b1;
        end
      end
      S_RESP: begin
        state_next = bus.instructionRequest ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        // A request still held after its response must fall before a new one is taken.
        if (!bus.instructionRequest) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Latency counter and captured request address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= 4'd0;
      addr_q <= 32'd0;
    end else if (capture) begin
      cnt    <= CNT_INIT;
      addr_q <= bus.instructionAddress;
    end else if (count_dec) begin
      cnt    <= cnt - 4'd1;
    end
  end

  // Response registers. They load only on the WAIT->RESP edge and otherwise hold.
  // mem is read before any loader write on the same edge takes effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.receivedInstruction <= 1'b0;
      bus.instruction         <= 32'd0;
      bus.cacheData           <= 64'd0;
      bus.addrError           <= 1'b0;
    end else begin
      bus.receivedInstruction <= fire;
      if (fire) begin
        if (req_bad) begin
          bus.instruction <= FILLER;
          bus.cacheData   <= {FILLER, FILLER};
          bus.addrError   <= 1'b1;
        end else begin
          bus.instruction <= mem[word_idx];
          bus.cacheData   <= {mem[line_hi_idx], mem[line_lo_idx]};
          bus.addrError   <= 1'b0;
        end
      end
    end
  end

  // Loader write port. It is active in every state and drops out-of-range addresses.
  always_ff @(posedge clk) begin
    if (bus.progWrite && prog_in_range) begin
      mem[prog_idx] <= bus.progData;
    end
  end

endmodule
